// File: rtl/divu_arbiter.sv
// divu_arbiter: round-robin sharing of one external divu divider among NREQ requesters.
// A watchdog converts a divide that never completes into a timeout response.
module divu_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_val,
    output logic                  rsp_dbz,
    output logic                  rsp_ovf,
    output logic                  rsp_tmo,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_a,
    output logic [WIDTH-1:0]      div_b,
    input  logic                  div_busy,
    input  logic                  div_done,
    input  logic                  div_dbz,
    input  logic                  div_ovf,
    input  logic [WIDTH-1:0]      div_val
);
    localparam int unsigned WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   id_q;
    logic [WDW-1:0]   wd_q;
    logic             div_start_q;
    logic [WIDTH-1:0] div_a_q;
    logic [WIDTH-1:0] div_b_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_val_q;
    logic             rsp_dbz_q;
    logic             rsp_ovf_q;
    logic             rsp_tmo_q;

    logic             grant_vld;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   cand;
    int unsigned      idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             can_grant;

    // Cyclic search starting just after the last granted requester.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx  = (32'(ptr_q) + i) % NREQ;
            cand = IDW'(idx);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
        sel_a = WIDTH'(req_a >> (32'(grant_id) * WIDTH));
        sel_b = WIDTH'(req_b >> (32'(grant_id) * WIDTH));
    end

    // rst_n gate keeps req_ready at zero while reset is held, even with a pending request.
    assign can_grant = rst_n && (state_q == S_IDLE) && !div_busy && grant_vld;

    always_comb begin
        req_ready = '0;
        if (can_grant) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            wd_q        <= '0;
            div_start_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_val_q   <= '0;
            rsp_dbz_q   <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (can_grant) begin
                        ptr_q       <= grant_id;
                        id_q        <= grant_id;
                        div_a_q     <= sel_a;
                        div_b_q     <= sel_b;
                        div_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_q    <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_done) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_val_q   <= div_val;
                        rsp_dbz_q   <= div_dbz;
                        rsp_ovf_q   <= div_ovf;
                        rsp_tmo_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_val_q   <= '0;
                        rsp_dbz_q   <= 1'b0;
                        rsp_ovf_q   <= 1'b0;
                        rsp_tmo_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign div_start = div_start_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_val   = rsp_val_q;
    assign rsp_dbz   = rsp_dbz_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_tmo   = rsp_tmo_q;

endmodule

// File: tb/tb_divu_arbiter.sv
// Bench for divu_arbiter: stub fixed-point divider, transaction-level reference model,
// directed scenarios followed by randomized traffic.
module tb_divu_arbiter;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int FBITS   = 4;
    localparam int IDW     = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_val;
    logic                  rsp_dbz, rsp_ovf, rsp_tmo;
    logic                  div_start;
    logic [WIDTH-1:0]      div_a, div_b;
    logic                  div_busy = 1'b0;
    logic                  div_done = 1'b0;
    logic                  div_dbz = 1'b0;
    logic                  div_ovf = 1'b0;
    logic [WIDTH-1:0]      div_val = '0;

    always #5 clk = ~clk;

    divu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_val(rsp_val),
        .rsp_dbz(rsp_dbz), .rsp_ovf(rsp_ovf), .rsp_tmo(rsp_tmo),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_done(div_done), .div_dbz(div_dbz), .div_ovf(div_ovf),
        .div_val(div_val)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Fixed-point quotient (a << FBITS) / b, returned as {dbz, ovf, val}.
    function automatic logic [WIDTH+1:0] fx_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int unsigned q;
        if (b == '0) return {2'b10, {WIDTH{1'b1}}};
        q = (32'(a) << FBITS) / 32'(b);
        if (q > ((1 << WIDTH) - 1)) return {2'b01, WIDTH'(0)};
        return {2'b00, WIDTH'(q)};
    endfunction

    // Stub divider: busy for stub_lat cycles then a done pulse; in hang mode it stays busy until released.
    logic             stub_hang = 1'b0;
    int               stub_lat = 3;
    int               stub_cnt = 0;
    logic             stub_fin;
    logic [WIDTH-1:0] sa = '0, sb = '0;

    always @(posedge clk) begin
        stub_fin = 1'b0;
        div_done <= 1'b0;
        div_val  <= WIDTH'($urandom);
        div_dbz  <= 1'($urandom);
        div_ovf  <= 1'($urandom);
        if (div_start) begin
            div_busy <= 1'b1;
            sa       <= div_a;
            sb       <= div_b;
            stub_cnt <= stub_hang ? -1 : stub_lat;
        end else if (stub_cnt < 0) begin
            stub_fin = !stub_hang;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            stub_fin = (stub_cnt == 1);
        end
        if (stub_fin) begin
            {div_dbz, div_ovf, div_val} <= fx_div(sa, sb);
            div_done <= 1'b1;
            div_busy <= 1'b0;
            stub_cnt <= 0;
        end
    end

    // Transaction-level reference model, evaluated on the falling edge.
    typedef struct { int id; logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } txn_t;
    txn_t            txq[$];
    int              dut_grants[$];
    int              waitcnt[NREQ];
    logic [NREQ-1:0] hs = '0;
    logic [NREQ-1:0] exp_rdy;
    int              cyc = 0, ptr = NREQ - 1, best, bestd, d, start_cyc = 0, rise_cyc = -1, n_acc = 0;
    logic            txn_open = 1'b0, exp_start = 1'b0, started = 1'b0, cur_hang = 1'b0;
    logic            rv_hold = 1'b0, exp_rv;
    logic            e_dbz, e_ovf;
    logic [WIDTH-1:0] e_val;
    int              last_id = 0;
    logic [WIDTH-1:0] last_val = '0;
    logic            last_dbz = 1'b0, last_ovf = 1'b0, last_tmo = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            ptr = NREQ - 1; txn_open = 1'b0; exp_start = 1'b0; started = 1'b0;
            rise_cyc = -1; rv_hold = 1'b0; hs = '0;
            txq.delete();
            for (int i = 0; i < NREQ; i++) waitcnt[i] = 0;
        end else begin
            best = -1; bestd = NREQ;
            if (!txn_open && !div_busy) begin
                for (int i = 0; i < NREQ; i++) begin
                    d = (i - ptr - 1 + 2 * NREQ) % NREQ;
                    if (((req_valid >> i) & 1) != 0 && d < bestd) begin
                        bestd = d; best = i;
                    end
                end
            end
            exp_rdy = (best >= 0) ? (NREQ'(1) << best) : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            hs = req_ready & req_valid;
            for (int i = 0; i < NREQ; i++) if (((req_ready >> i) & 1) != 0) dut_grants.push_back(i);
            for (int i = 0; i < NREQ; i++) if (((req_valid >> i) & 1) == 0) waitcnt[i] = 0;
            if (best >= 0) begin
                chk("fairness", 32'(waitcnt[best] <= NREQ - 1), 32'd1);
                for (int i = 0; i < NREQ; i++) if (i != best && ((req_valid >> i) & 1) != 0) waitcnt[i]++;
                waitcnt[best] = 0;
                txq.push_back('{id: best, a: WIDTH'(req_a >> (best * WIDTH)), b: WIDTH'(req_b >> (best * WIDTH))});
                ptr = best;
                txn_open = 1'b1;
            end

            chk("div_start", 32'(div_start), 32'(exp_start));
            if (div_start && txq.size() > 0) begin
                chk("div_a", 32'(div_a), 32'(txq[0].a));
                chk("div_b", 32'(div_b), 32'(txq[0].b));
                started   = 1'b1;
                start_cyc = cyc;
                cur_hang  = stub_hang;
                rise_cyc  = stub_hang ? cyc + TIMEOUT + 1 : -1;
            end
            exp_start = (best >= 0);

            if (div_done && started && !cur_hang && rise_cyc < 0) rise_cyc = cyc + 1;
            exp_rv = rv_hold || (cyc == rise_cyc);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv && txq.size() > 0) begin
                if (cur_hang) {e_dbz, e_ovf, e_val} = '0;
                else {e_dbz, e_ovf, e_val} = fx_div(txq[0].a, txq[0].b);
                chk("rsp_id", 32'(rsp_id), 32'(txq[0].id));
                chk("rsp_val", 32'(rsp_val), 32'(e_val));
                chk("rsp_dbz", 32'(rsp_dbz), 32'(e_dbz));
                chk("rsp_ovf", 32'(rsp_ovf), 32'(e_ovf));
                chk("rsp_tmo", 32'(rsp_tmo), 32'(cur_hang));
            end
            if (exp_rv && rsp_ready) begin
                last_id = int'(rsp_id); last_val = rsp_val;
                last_dbz = rsp_dbz; last_ovf = rsp_ovf; last_tmo = rsp_tmo;
                if (txq.size() > 0) void'(txq.pop_front());
                txn_open = 1'b0; started = 1'b0; rise_cyc = -1; rv_hold = 1'b0;
                n_acc++;
            end else begin
                rv_hold = exp_rv;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_val", 32'(rsp_val), 32'd0);
        chk("rst_rsp_flags", 32'({rsp_dbz, rsp_ovf, rsp_tmo}), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_div_ops", 32'({div_a, div_b}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int id);
        int k = 0;
        while (((hs >> id) & 1) == 0 && k < 200) begin tick(); k++; end
        chk("grant_wait", 32'((hs >> id) & 1), 32'd1);
    endtask

    task automatic wait_acc(input int n0);
        int k = 0;
        while (n_acc == n0 && k < 200) begin tick(); k++; end
        chk("accept_wait", 32'(n_acc > n0), 32'd1);
    endtask

    task automatic wait_rv();
        int k = 0;
        while (!rsp_valid && k < 100) begin tick(); k++; end
        chk("rsp_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic set_ops(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
    endtask

    task automatic send(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n0 = n_acc;
        set_ops(id, a, b);
        req_valid[id] = 1'b1;
        wait_grant(id);
        req_valid[id] = 1'b0;
        wait_acc(n0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout, expected end of test");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        int base, k;
        do_reset();

        send(2, 8'h30, 8'h20);
        chk("single_id", 32'(last_id), 32'd2);
        chk("single_val", 32'(last_val), 32'h18);
        chk("single_flags", 32'({last_dbz, last_ovf, last_tmo}), 32'd0);

        send(0, 8'h10, 8'h00);
        chk("dbz_id", 32'(last_id), 32'd0);
        chk("dbz_flags", 32'({last_dbz, last_ovf, last_tmo}), 32'b100);

        send(1, 8'h80, 8'h08);
        chk("ovf_flags", 32'({last_dbz, last_ovf, last_tmo}), 32'b010);
        chk("ovf_val", 32'(last_val), 32'd0);

        // All requesters pending from reset: grants must rotate 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) set_ops(i, WIDTH'(8'h10 * (i + 1)), 8'h20);
        req_valid = '1;
        base = dut_grants.size();
        do_reset();
        k = 0;
        while (dut_grants.size() < base + 5 && k < 300) begin tick(); k++; end
        req_valid = '0;
        chk("rr_count", 32'(dut_grants.size() >= base + 5), 32'd1);
        repeat (30) tick();
        for (int j = 0; j < 5; j++)
            if (dut_grants.size() > base + j) chk("rr_order", 32'(dut_grants[base+j]), 32'(j % NREQ));

        // Backpressure with requesters 1 and 3 pending.
        rsp_ready = 1'b0;
        base = dut_grants.size();
        set_ops(1, 8'h44, 8'h11);
        set_ops(3, 8'h21, 8'h03);
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        wait_rv();
        req_valid[1] = 1'b0;
        repeat (5) tick();
        chk("bp_no_grant", 32'(dut_grants.size()), 32'(base + 1));
        rsp_ready = 1'b1;
        wait_grant(3);
        req_valid[3] = 1'b0;
        if (dut_grants.size() >= base + 2) begin
            chk("bp_first", 32'(dut_grants[base]), 32'd1);
            chk("bp_second", 32'(dut_grants[base+1]), 32'd3);
        end
        repeat (30) tick();

        // Hung divider: watchdog response, then no grant while busy stays high.
        stub_hang = 1'b1;
        rsp_ready = 1'b0;
        set_ops(0, 8'h40, 8'h10);
        req_valid[0] = 1'b1;
        wait_grant(0);
        req_valid[0] = 1'b0;
        wait_rv();
        chk("tmo_flag", 32'(rsp_tmo), 32'd1);
        chk("tmo_val", 32'(rsp_val), 32'd0);
        set_ops(1, 8'h20, 8'h40);
        req_valid[1] = 1'b1;
        repeat (3) tick();
        rsp_ready = 1'b1;
        base = dut_grants.size();
        repeat (6) tick();
        chk("busy_no_grant", 32'(dut_grants.size()), 32'(base));
        stub_hang = 1'b0;
        k = n_acc;
        wait_grant(1);
        req_valid[1] = 1'b0;
        wait_acc(k);
        chk("after_tmo_val", 32'(last_val), 32'h08);

        // Reset while a divide is in WAIT.
        stub_lat = 10;
        set_ops(2, 8'h55, 8'h07);
        req_valid[2] = 1'b1;
        wait_grant(2);
        req_valid[2] = 1'b0;
        repeat (3) tick();
        set_ops(0, 8'h12, 8'h34);
        req_valid[0] = 1'b1;
        do_reset();
        k = n_acc;
        wait_grant(0);
        req_valid[0] = 1'b0;
        wait_acc(k);
        chk("post_rst_id", 32'(last_id), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            tick();
            rsp_ready = ($urandom_range(0, 3) != 0);
            stub_lat = $urandom_range(1, 10);
            for (int i = 0; i < NREQ; i++) begin
                if (((hs >> i) & 1) != 0) begin
                    if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                    else set_ops(i, WIDTH'($urandom), ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom));
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 4) == 0) begin
                        set_ops(i, WIDTH'($urandom), ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom));
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/divu_arbiter.md
Name: divu_arbiter

Overview:
Shares one external `divu` fixed-point divider between NREQ requesters. Arbitration is round-robin. The block drives the divider's start/operand interface and waits for its one-cycle done pulse. It returns each result (quotient plus dbz/ovf status) over a valid/ready response channel tagged with the requester id. A watchdog turns a hung divide into an error response.

Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, operand/result width; must match the divider's WIDTH
- TIMEOUT, 64, max cycles in WAIT before a timeout response (≥ 2*WIDTH+4)
- IDW, $clog2(NREQ), width of requester id

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  divisors, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  IDW  requester index of the response
- rsp_val  out  WIDTH  quotient
- rsp_dbz  out  1  divide by zero
- rsp_ovf  out  1  overflow
- rsp_tmo  out  1  watchdog timeout
- div_start  out  1  divider start, one-cycle pulse
- div_a, div_b  out  WIDTH  divider operands
- div_busy  in  1  divider busy
- div_done  in  1  divider done pulse
- div_dbz, div_ovf  in  1  divider status
- div_val  in  WIDTH  divider quotient

Behaviour:
- Reset (rst_n=0, async) values:
  - state=IDLE; rr pointer=NREQ-1, so requester 0 has first priority.
  - req_ready=0, rsp_valid=0, rsp_id/val/dbz/ovf/tmo=0.
  - div_start=0, div_a=div_b=0, watchdog=0.
- State IDLE:
  - If any req_valid and div_busy=0, grant g = first requester with req_valid set, searching cyclically from pointer+1.
  - req_ready[g]=1 combinationally this cycle. The handshake completes in this cycle.
  - Latch req_a[g], req_b[g] and id=g; pointer<=g; go to ISSUE.
  - If div_busy=1, there is no grant and req_ready=0.
- State ISSUE:
  - div_start=1 (registered) for exactly this one cycle.
  - div_a/div_b show the latched operands from ISSUE until the next grant.
  - Clear the watchdog; go to WAIT.
- State WAIT:
  - div_done is sampled only here; a div_done in any other state is ignored.
  - On div_done: capture rsp_val=div_val, rsp_dbz=div_dbz, rsp_ovf=div_ovf, rsp_tmo=0, and go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 without div_done: rsp_val=0, rsp_dbz=rsp_ovf=0, rsp_tmo=1, go to RESP.
  - Any late done from that divide is ignored.
  - The next grant waits for div_busy=0.
- State RESP:
  - rsp_valid=1 and all rsp_* fields stay stable until rsp_ready=1.
  - On the cycle with rsp_valid && rsp_ready, go to IDLE; rsp_valid=0 next cycle.
  - No new grant is issued while in RESP.
- Latency: grant cycle, +1 ISSUE, then WAIT (divider latency), then RESP. The minimum spacing of grants is the divide time plus 3 cycles.
- Fairness: a requester holding req_valid waits at most NREQ-1 other transactions before its grant.
- req_valid may drop without a grant; no state is affected.
- Simultaneous requests: exactly one grant per IDLE cycle.
- Reset mid-operation:
  - Immediate return to IDLE with reset outputs and the pending transaction lost.
  - The divider has its own reset; after release the block waits for div_busy=0 before the next grant.

Test Plan:
- Single request, WIDTH=8 with divider FBITS=4: requester 2 sends a=0x30, b=0x20 → one div_start pulse, then rsp_valid with rsp_id=2, rsp_val=0x18, dbz=ovf=tmo=0.
- Divide by zero: requester 0 sends a=0x10, b=0x00 → rsp_dbz=1, rsp_ovf=0, rsp_tmo=0, rsp_id=0.
- Overflow: a=0x80, b=0x08 → rsp_ovf=1, rsp_val=0.
- Contention: all 4 req_valid held high from reset, rsp_ready=1 → grants in order 0,1,2,3,0. Each req_ready is one-hot and exactly one div_start occurs per grant.
- Backpressure: rsp_ready=0 for 5 cycles while req 1 and req 3 are pending → rsp fields stable, no req_ready and no div_start until acceptance; then req 3 is granted (pointer was 1).
- Timeout and reset:
  - Stub divider never asserts done (busy=1), TIMEOUT=16 → rsp_tmo=1 after 16 WAIT cycles; no grant until busy drops.
  - Separately, rst_n low in WAIT → all outputs return to reset values within the same cycle.
